// File: rtl/btn_pkg.sv
// Shared constants for the ULX3S pushbutton bank: channel indices, default
// polarity mask, 25 MHz timing defaults and the counter step decode.
package btn_pkg;

    localparam int BTN_PWR   = 0;
    localparam int BTN_F1    = 1;
    localparam int BTN_F2    = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 4;
    localparam int BTN_LEFT  = 5;
    localparam int BTN_RIGHT = 6;

    localparam int         N_BTN_DEFAULT           = 7;
    localparam logic [6:0] BTN_INVERT_DEFAULT      = 7'b0000001;
    localparam int         DEBOUNCE_CYCLES_DEFAULT = 250000;
    localparam int         REPEAT_DELAY_DEFAULT    = 12500000;
    localparam int         REPEAT_PERIOD_DEFAULT   = 2500000;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DN
    } step_e;

    // Simultaneous up and down cancel out.
    function automatic step_e step_decode(input logic up, input logic dn);
        if (up && !dn) return STEP_UP;
        if (dn && !up) return STEP_DN;
        return STEP_NONE;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, counter debounce, press/release
// pulses and hold-to-auto-repeat, all registered in the clk domain.
module btn_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000,
    parameter bit INVERT          = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DW    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int R_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW    = $clog2(R_MAX) + 1;

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          s;
    logic [DW-1:0] d_cnt;
    logic          accept;

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // so sync[1] really is one cycle behind sync[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b00;
        else        sync <= {sync[0], pin};
    end

    assign s      = sync[1] ^ INVERT;
    assign accept = (s != level) && (d_cnt == D_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level         <= 1'b0;
            d_cnt         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= accept & s;
            release_pulse <= accept & ~s;
            if (accept) begin
                level <= s;
                d_cnt <= '0;
            end else if (s != level) begin
                d_cnt <= d_cnt + 1'b1;
            end else begin
                d_cnt <= '0;
            end
        end
    end

    if (REPEAT_PERIOD > 0) begin : g_repeat
        localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

        logic [RW-1:0] r_cnt;
        logic          in_period;
        logic          held;
        logic          r_hit;

        // A release being accepted this edge already counts as not held.
        assign held  = level && !accept;
        assign r_hit = held && (r_cnt == (in_period ? PERIOD_LAST : DELAY_LAST));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt        <= '0;
                in_period    <= 1'b0;
                repeat_pulse <= 1'b0;
            end else begin
                repeat_pulse <= r_hit;
                if (!held) begin
                    r_cnt     <= '0;
                    in_period <= 1'b0;
                end else if (r_hit) begin
                    r_cnt     <= '0;
                    in_period <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end else begin : g_no_repeat
        assign repeat_pulse = 1'b0;
    end

endmodule

// File: rtl/btn_bank_counter.sv
// N-channel pushbutton front-end with an up/down counter stepped by the
// press/repeat pulses of two selectable channels.
module btn_bank_counter
    import btn_pkg::*;
#(
    parameter int               N_BTN           = N_BTN_DEFAULT,
    parameter logic [N_BTN-1:0] BTN_INVERT      = N_BTN'(BTN_INVERT_DEFAULT),
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int               REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int               REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
    parameter int               CNT_W           = 4,
    parameter int               UP_IDX          = BTN_F2,
    parameter int               DN_IDX          = BTN_F1,
    parameter bit               SATURATE        = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o,
    output logic [N_BTN-1:0] btn_repeat_o,
    output logic [CNT_W-1:0] count_o,
    output logic             count_ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .INVERT         (BTN_INVERT[i])
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .pin          (btn_i[i]),
            .level        (btn_level_o[i]),
            .press_pulse  (btn_press_o[i]),
            .release_pulse(btn_release_o[i]),
            .repeat_pulse (btn_repeat_o[i])
        );
    end

    logic up;
    logic dn;

    assign up = btn_press_o[UP_IDX] | btn_repeat_o[UP_IDX];
    assign dn = btn_press_o[DN_IDX] | btn_repeat_o[DN_IDX];

    // Limit hits always pulse ovf; only the wrap itself depends on SATURATE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_o     <= '0;
            count_ovf_o <= 1'b0;
        end else begin
            count_ovf_o <= 1'b0;
            unique case (step_decode(up, dn))
                STEP_UP: begin
                    if (count_o == CNT_MAX) begin
                        count_ovf_o <= 1'b1;
                        if (!SATURATE) count_o <= '0;
                    end else begin
                        count_o <= count_o + 1'b1;
                    end
                end
                STEP_DN: begin
                    if (count_o == '0) begin
                        count_ovf_o <= 1'b1;
                        if (!SATURATE) count_o <= CNT_MAX;
                    end else begin
                        count_o <= count_o - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_bank_counter.sv
// Scoreboard bench: stimulus queues the expected output events by cycle, a
// negedge monitor pops and compares whenever either DUT shows activity.
module tb_btn_bank_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] btn;

    logic [6:0] level, press, rel, rpt;
    logic [6:0] level_s, press_s, rel_s, rpt_s;
    logic [3:0] count, count_s;
    logic       ovf, ovf_s;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        int         cyc;
        logic [6:0] level;
        logic [6:0] press;
        logic [6:0] rel;
        logic [6:0] rpt;
        logic [3:0] count;
        logic       ovf;
        logic [3:0] count_s;
        logic       ovf_s;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] exp_level;
    logic [3:0] exp_cnt, exp_cnt_s;

    btn_bank_counter #(
        .N_BTN(7), .BTN_INVERT(7'b0000001), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3), .CNT_W(4), .UP_IDX(2), .DN_IDX(1), .SATURATE(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_i(btn), .btn_level_o(level), .btn_press_o(press),
        .btn_release_o(rel), .btn_repeat_o(rpt), .count_o(count), .count_ovf_o(ovf)
    );

    btn_bank_counter #(
        .N_BTN(7), .BTN_INVERT(7'b0000001), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3), .CNT_W(4), .UP_IDX(2), .DN_IDX(1), .SATURATE(1'b1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .btn_i(btn), .btn_level_o(level_s), .btn_press_o(press_s),
        .btn_release_o(rel_s), .btn_repeat_o(rpt_s), .count_o(count_s), .count_ovf_o(ovf_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void push(input exp_t e);
        int i = 0;
        while (i < exp_q.size() && exp_q[i].cyc <= e.cyc) i++;
        exp_q.insert(i, e);
    endfunction

    // Queue the pulse event at cycle c and, if it steps the counter, the
    // counter update one cycle later. Calls must be made in event order.
    task automatic ev(input int c, input logic [6:0] prs, input logic [6:0] rl, input logic [6:0] rp);
        exp_t e;
        logic up, dn;
        exp_level = (exp_level | prs) & ~rl;
        e = '{cyc: c, level: exp_level, press: prs, rel: rl, rpt: rp,
              count: exp_cnt, ovf: 1'b0, count_s: exp_cnt_s, ovf_s: 1'b0};
        push(e);
        up = prs[2] | rp[2];
        dn = prs[1] | rp[1];
        if (up != dn) begin
            e.cyc   = c + 1;
            e.press = '0;
            e.rel   = '0;
            e.rpt   = '0;
            if (up) begin
                e.ovf   = (exp_cnt == 4'd15);
                exp_cnt = exp_cnt + 4'd1;
                e.ovf_s = (exp_cnt_s == 4'd15);
                if (exp_cnt_s != 4'd15) exp_cnt_s = exp_cnt_s + 4'd1;
            end else begin
                e.ovf   = (exp_cnt == 4'd0);
                exp_cnt = exp_cnt - 4'd1;
                e.ovf_s = (exp_cnt_s == 4'd0);
                if (exp_cnt_s != 4'd0) exp_cnt_s = exp_cnt_s - 4'd1;
            end
            e.count   = exp_cnt;
            e.count_s = exp_cnt_s;
            push(e);
        end
    endtask

    // Clean press and release of one channel (pin active-high channels only).
    task automatic tap(input int ch);
        int         c;
        logic [6:0] m;
        m      = 7'(1 << ch);
        c      = cyc;
        btn    = btn | m;
        ev(c + 6, m, '0, '0);
        step(7);
        btn    = btn & ~m;
        ev(c + 13, '0, m, '0);
        step(10);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   {25'd0, level},   0);
        check({tag, "_pulses"},  {11'd0, press, rel, rpt}, 0);
        check({tag, "_count"},   {28'd0, count},   0);
        check({tag, "_ovf"},     {31'd0, ovf},     0);
        check({tag, "_level_s"}, {25'd0, level_s}, 0);
        check({tag, "_count_s"}, {28'd0, count_s}, 0);
        check({tag, "_ovf_s"},   {31'd0, ovf_s},   0);
    endtask

    // Monitor
    logic [3:0] prev_cnt, prev_cnt_s;
    logic       seen;
    exp_t       got;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cnt   = '0;
            prev_cnt_s = '0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("missed_event_cycle", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            seen = (|press) | (|rel) | (|rpt) | ovf | ovf_s |
                   (count != prev_cnt) | (count_s != prev_cnt_s);
            if (seen) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event_cycle", cyc, 32'hFFFF_FFFF);
                end else begin
                    got = exp_q.pop_front();
                    check("event_cycle", cyc, got.cyc);
                    check("level",   {25'd0, level},   {25'd0, got.level});
                    check("press",   {25'd0, press},   {25'd0, got.press});
                    check("release", {25'd0, rel},     {25'd0, got.rel});
                    check("repeat",  {25'd0, rpt},     {25'd0, got.rpt});
                    check("count",   {28'd0, count},   {28'd0, got.count});
                    check("ovf",     {31'd0, ovf},     {31'd0, got.ovf});
                    check("count_sat", {28'd0, count_s}, {28'd0, got.count_s});
                    check("ovf_sat",   {31'd0, ovf_s},   {31'd0, got.ovf_s});
                end
            end
            prev_cnt   = count;
            prev_cnt_s = count_s;
        end
    end

    initial begin
        int c, p, r;
        exp_level = '0;
        exp_cnt   = '0;
        exp_cnt_s = '0;
        btn       = 7'b0000001;
        rst_n     = 1'b0;
        #1;
        check_all_zero("reset");
        step(3);
        rst_n = 1'b1;
        step(5);

        // Held press: press after 6, repeats at +10,+13,...,+37, none in release cycle.
        c   = cyc;
        btn[2] = 1'b1;
        p   = c + 6;
        ev(p, 7'b0000100, '0, '0);
        for (int k = 0; k < 10; k++) ev(p + 10 + 3 * k, '0, '0, 7'b0000100);
        step(40);
        btn[2] = 1'b0;
        ev(p + 40, '0, 7'b0000100, '0);
        step(12);

        // Bounce 1,0,1,0 every 2 cycles then steady 1: a single press.
        c = cyc;
        btn[2] = 1'b1; step(2);
        btn[2] = 1'b0; step(2);
        btn[2] = 1'b1; step(2);
        btn[2] = 1'b0; step(2);
        btn[2] = 1'b1;
        ev(c + 14, 7'b0000100, '0, '0);
        step(6);
        btn[2] = 1'b0;
        ev(c + 20, '0, 7'b0000100, '0);
        step(10);

        // Count 12 -> 15, then wrap up (sat: hold at 15), then wrap down.
        for (int k = 0; k < 4; k++) tap(2);
        tap(1);

        // Up and down pressed together: no step, no ovf.
        c = cyc;
        btn[2:1] = 2'b11;
        ev(c + 6, 7'b0000110, '0, '0);
        step(7);
        btn[2:1] = 2'b00;
        ev(c + 13, '0, 7'b0000110, '0);
        step(10);

        // Active-low channel 0.
        c = cyc;
        btn[0] = 1'b0;
        ev(c + 6, 7'b0000001, '0, '0);
        step(7);
        btn[0] = 1'b1;
        ev(c + 13, '0, 7'b0000001, '0);
        step(10);

        // Reset mid-debounce, button kept held through reset release.
        btn[2] = 1'b1;
        step(4);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        step(3);
        rst_n     = 1'b1;
        r         = cyc;
        exp_level = '0;
        exp_cnt   = '0;
        exp_cnt_s = '0;
        ev(r + 6, 7'b0000100, '0, '0);
        step(8);
        btn[2] = 1'b0;
        ev(r + 14, '0, 7'b0000100, '0);
        step(12);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
